pacman_mover: RTL and testbench
===============================

# pacman_mover

Position controller that produces the Pac-Man tile coordinates consumed by the sprite renderer. Once per game tick it evaluates the player's requested direction against the maze wall map and either turns, continues in the current direction, or stops, then updates the tile position. It sits between the keyboard/button decoder and the renderer, and queries a registered maze-wall ROM over a one-cycle request/response interface.

## Interface
- TICK_CYCLES, 5_000_000, clock cycles per game tick; minimum 8
- COLS, 19, maze width in tiles
- ROWS, 21, maze height in tiles
- START_X, 9, reset column
- START_Y, 15, reset row
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gameover  in  1  freezes movement while high
- dir_valid  in  1  one-cycle pulse, new direction request
- dir_req  in  2  requested direction: 0 right, 1 up, 2 left, 3 down
- wall  in  1  wall bit for the tile addressed by query_x/query_y in the previous cycle
- query_x  out  5  wall ROM column address
- query_y  out  5  wall ROM row address
- pac_x  out  5  current column, to renderer
- pac_y  out  5  current row, to renderer
- pac_dir  out  2  current heading
- moved  out  1  one-cycle pulse, coincident with a position update
- busy  out  1  high whenever FSM is not IDLE

## Operation
- Reset values: pac_x=START_X, pac_y=START_Y, pac_dir=2 (left), moved=0, busy=0, query_x=0, query_y=0, pending invalid, tick counter 0, FSM IDLE.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. Tick = counter at TICK_CYCLES-1. Counter holds while gameover=1.
- Pending register: dir_valid=1 loads dir_req and sets pending-valid. A new press always overwrites. A press in the same cycle that the pending value is adopted wins, and pending stays valid with the new value. Presses are ignored while gameover=1.
- FSM states:
  - IDLE: on a tick with gameover=0, go to Q_REQ if pending is valid, else go to Q_CUR.
  - Q_REQ: drive the neighbour of (pac_x, pac_y) in the pending direction; go to W_REQ.
  - W_REQ: if the target is clear, go to MOVE with the pending direction and clear pending-valid. If it is a wall, go to Q_CUR.
  - Q_CUR: drive the neighbour in pac_dir; go to W_CUR.
  - W_CUR: if clear, go to MOVE with pac_dir. If it is a wall, go to IDLE with no update.
  - MOVE: on the exiting edge, load the target into pac_x/pac_y, load the chosen direction into pac_dir, pulse moved for one cycle, then go to IDLE.
- Neighbour arithmetic:
  - Right/left wrap horizontally (tunnel): col COLS-1 + right → 0; col 0 + left → COLS-1. Wrapped targets are still wall-checked.
  - Up from row 0 or down from row ROWS-1 is out of range and counts as a wall. The wall input is ignored in the following W state.
- gameover=1 in any non-IDLE state: abort with no position or direction update, go to IDLE next edge, moved=0.
- End of each tick evaluation: pending handling depends on PACMAN_TURN_BUFFER_EN (see Configuration).

## Timing
- Tick cycle = cycle N.
- No pending: Q_CUR at N+1, W_CUR at N+2, MOVE at N+3, new position and moved visible at N+4.
- Pending clear: Q_REQ at N+1, W_REQ at N+2, MOVE at N+3, visible at N+4.
- Pending blocked, current clear: MOVE at N+5, visible at N+6.
- Fully blocked: back in IDLE at N+5, no update.
- query_x/query_y are registered and valid during the Q states. wall is sampled in the W state (one-cycle ROM latency).
- Ticks arriving while busy=1 cannot occur for TICK_CYCLES≥8; behaviour in that case is unspecified.
- Reset mid-evaluation: all registers return to reset values on that edge.

## Configuration
- PACMAN_TURN_BUFFER_EN defined: pending persists across ticks until it is adopted or overwritten. This is pre-turn buffering: a press before a corridor opens takes effect at the first legal tick.
- PACMAN_TURN_BUFFER_EN undefined: pending-valid is cleared at the end of every tick evaluation, whether adopted or not. A turn must therefore be legal at the very next tick.

## Test plan
- Reset, TICK_CYCLES=16, open maze, no input → pac_x steps 9→8→7 left on successive ticks; moved pulses at N+4; pac_y stays 15.
- At (9,15) heading left, press up (1), tile (9,14) clear → at the tick, pac_dir=1 and pac_y=14 at N+4; pending cleared.
- Press up with (9,14) a wall and (8,15) clear → pac_x=8 at N+6, pac_dir stays 2. With the macro defined, the turn is taken at the first later tick where up is clear. With the macro undefined, no turn occurs later.
- Heading left at column 0 with (18,y) clear → pac_x=18. Heading right at column 18 → pac_x=0.
- Heading up at row 0 → no move, moved=0, FSM back in IDLE at N+5. Wall input driven 0 throughout, to prove it is ignored.
- gameover asserted at N+2 → no update, IDLE at N+3. Counter frozen while gameover is held. Reset asserted at N+3 → pac_x=9, pac_y=15, pac_dir=2 on the next cycle.

Source files
------------

// File: rtl/pacman_mover_if.sv
// Wall-ROM query bus between the Pac-Man position controller and the maze ROM.
// The ROM answers one cycle after the address is presented.
interface pacman_mover_if;
    logic [4:0] query_x;
    logic [4:0] query_y;
    logic       wall;

    modport master (
        output query_x,
        output query_y,
        input  wall
    );

    modport slave (
        input  query_x,
        input  query_y,
        output wall
    );
endinterface

// File: rtl/pacman_mover.sv
// Tick-driven Pac-Man tile position controller with wall-ROM lookahead.
// Optional pre-turn buffering is enabled with `define PACMAN_TURN_BUFFER_EN.
module pacman_mover #(
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter int unsigned COLS        = 19,
    parameter int unsigned ROWS        = 21,
    parameter int unsigned START_X     = 9,
    parameter int unsigned START_Y     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gameover,
    input  logic                  dir_valid,
    input  logic [1:0]            dir_req,
    pacman_mover_if.master        rom,
    output logic [4:0]            pac_x,
    output logic [4:0]            pac_y,
    output logic [1:0]            pac_dir,
    output logic                  moved,
    output logic                  busy
);

    localparam int unsigned CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [4:0]    COL_LAST  = 5'(COLS - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);
    localparam logic [4:0]    RST_X     = 5'(START_X);
    localparam logic [4:0]    RST_Y     = 5'(START_Y);
    localparam logic [1:0]    DIR_LEFT  = 2'd2;

`ifdef PACMAN_TURN_BUFFER_EN
    localparam logic TURN_BUFFER = 1'b1;
`else
    localparam logic TURN_BUFFER = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        Q_REQ = 3'd1,
        W_REQ = 3'd2,
        Q_CUR = 3'd3,
        W_CUR = 3'd4,
        MOVE  = 3'd5
    } state_t;

    typedef struct packed {
        logic       oob;
        logic [4:0] x;
        logic [4:0] y;
    } nbr_t;

    // Horizontal moves wrap through the tunnel; vertical moves off the maze are out of range.
    function automatic nbr_t neighbour(input logic [4:0] x, input logic [4:0] y,
                                       input logic [1:0] d);
        nbr_t n;
        n.oob = 1'b0;
        n.x   = x;
        n.y   = y;
        case (d)
            2'd0: n.x = (x == COL_LAST) ? 5'd0 : x + 5'd1;
            2'd1: begin
                if (y == 5'd0) n.oob = 1'b1;
                else           n.y   = y - 5'd1;
            end
            2'd2: n.x = (x == 5'd0) ? COL_LAST : x - 5'd1;
            2'd3: begin
                if (y == ROW_LAST) n.oob = 1'b1;
                else               n.y   = y + 5'd1;
            end
            default: n.oob = 1'b1;
        endcase
        return n;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] tick_cnt_r;
    logic          tick_s;
    logic          pend_valid_r;
    logic [1:0]    pend_dir_r;
    logic [4:0]    pac_x_r;
    logic [4:0]    pac_y_r;
    logic [1:0]    pac_dir_r;
    logic [4:0]    query_x_r;
    logic [4:0]    query_y_r;
    logic          oob_r;
    logic [1:0]    q_dir_r;
    logic          moved_r;
    logic          busy_r;
    logic          blocked_s;
    logic          q_load_s;
    logic [1:0]    q_dir_s;
    logic          commit_s;
    logic          adopt_s;
    logic          done_s;
    logic          pend_clr_s;
    nbr_t          nbr_s;

    assign tick_s     = (tick_cnt_r == TICK_LAST);
    assign blocked_s  = oob_r | rom.wall;
    assign nbr_s      = neighbour(pac_x_r, pac_y_r, q_dir_s);
    assign pend_clr_s = adopt_s | (done_s & ~TURN_BUFFER);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // FSM next-state logic; gameover aborts any evaluation in progress
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (tick_s && !gameover) state_next_s = pend_valid_r ? Q_REQ : Q_CUR;
                else                     state_next_s = IDLE;
            end
            Q_REQ: state_next_s = gameover ? IDLE : W_REQ;
            W_REQ: begin
                if (gameover)       state_next_s = IDLE;
                else if (blocked_s) state_next_s = Q_CUR;
                else                state_next_s = MOVE;
            end
            Q_CUR: state_next_s = gameover ? IDLE : W_CUR;
            W_CUR: begin
                if (gameover || blocked_s) state_next_s = IDLE;
                else                       state_next_s = MOVE;
            end
            MOVE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output strobes driving the query, pending and position registers
    always_comb begin
        q_load_s = 1'b0;
        q_dir_s  = pac_dir_r;
        commit_s = 1'b0;
        adopt_s  = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (state_next_s == Q_REQ) begin
                    q_load_s = 1'b1;
                    q_dir_s  = pend_dir_r;
                end else if (state_next_s == Q_CUR) begin
                    q_load_s = 1'b1;
                end else begin
                    q_load_s = 1'b0;
                end
            end
            W_REQ: begin
                if (state_next_s == Q_CUR)     q_load_s = 1'b1;
                else if (state_next_s == MOVE) adopt_s  = 1'b1;
                else                           done_s   = 1'b1;
            end
            Q_REQ, Q_CUR, W_CUR: begin
                done_s = (state_next_s == IDLE);
            end
            MOVE: begin
                commit_s = ~gameover;
                done_s   = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Game tick counter, frozen during gameover
    always_ff @(posedge clk) begin
        if (reset)          tick_cnt_r <= '0;
        else if (!gameover) tick_cnt_r <= tick_s ? '0 : tick_cnt_r + CW'(1);
        else                tick_cnt_r <= tick_cnt_r;
    end

    // Pending direction request; a fresh press beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_dir_r   <= 2'd0;
        end else if (dir_valid && !gameover) begin
            pend_valid_r <= 1'b1;
            pend_dir_r   <= dir_req;
        end else if (pend_clr_s) begin
            pend_valid_r <= 1'b0;
        end
    end

    // Query address, chosen heading and registered position outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            query_x_r <= 5'd0;
            query_y_r <= 5'd0;
            oob_r     <= 1'b0;
            q_dir_r   <= DIR_LEFT;
            pac_x_r   <= RST_X;
            pac_y_r   <= RST_Y;
            pac_dir_r <= DIR_LEFT;
            moved_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            moved_r <= commit_s;
            busy_r  <= (state_next_s != IDLE);
            if (q_load_s) begin
                query_x_r <= nbr_s.x;
                query_y_r <= nbr_s.y;
                oob_r     <= nbr_s.oob;
                q_dir_r   <= q_dir_s;
            end
            if (commit_s) begin
                pac_x_r   <= query_x_r;
                pac_y_r   <= query_y_r;
                pac_dir_r <= q_dir_r;
            end
        end
    end

    assign rom.query_x = query_x_r;
    assign rom.query_y = query_y_r;
    assign pac_x       = pac_x_r;
    assign pac_y       = pac_y_r;
    assign pac_dir     = pac_dir_r;
    assign moved       = moved_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_pacman_mover.sv
// Randomised and directed bench for pacman_mover against a per-tick movement model.
module tb_pacman_mover;

    localparam int TICK = 16;
    localparam int COLS = 19;
    localparam int ROWS = 21;
    localparam int SX   = 9;
    localparam int SY   = 15;

`ifdef PACMAN_TURN_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       gameover  = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req   = 2'd0;
    logic [4:0] pac_x;
    logic [4:0] pac_y;
    logic [1:0] pac_dir;
    logic       moved;
    logic       busy;

    pacman_mover_if rom_if ();

    pacman_mover #(
        .TICK_CYCLES(TICK),
        .COLS       (COLS),
        .ROWS       (ROWS),
        .START_X    (SX),
        .START_Y    (SY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .gameover (gameover),
        .dir_valid(dir_valid),
        .dir_req  (dir_req),
        .rom      (rom_if),
        .pac_x    (pac_x),
        .pac_y    (pac_y),
        .pac_dir  (pac_dir),
        .moved    (moved),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    bit maze [ROWS][COLS];

    // Registered maze ROM: one cycle of latency, off-map addresses read as wall
    always @(posedge clk) begin
        if (int'(rom_if.query_x) < COLS && int'(rom_if.query_y) < ROWS)
            rom_if.wall <= maze[int'(rom_if.query_y)][int'(rom_if.query_x)];
        else
            rom_if.wall <= 1'b1;
    end

    int cyc;
    int next_tick;
    int errors;
    int checks;
    int m_x, m_y, m_dir, m_pd;
    bit m_pv;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic fill_maze(input int pct);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                maze[r][c] = ($urandom_range(99) < pct);
    endtask

    task automatic model_reset();
        m_x = SX; m_y = SY; m_dir = 2; m_pv = 1'b0; m_pd = 0;
        cyc = 0;
        next_tick = TICK - 1;
    endtask

    task automatic do_reset();
        gameover  = 1'b0;
        dir_valid = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
    endtask

    function automatic void nbr(input int x, input int y, input int d,
                                output int nx, output int ny, output bit oob);
        int dx, dy;
        dx = (d == 0) ? 1 : (d == 2) ? -1 : 0;
        dy = (d == 1) ? -1 : (d == 3) ? 1 : 0;
        nx  = (x + dx + COLS) % COLS;
        ny  = y + dy;
        oob = (ny < 0) || (ny >= ROWS);
    endfunction

    task automatic check_home(input string tag);
        check_eq({tag, "_x"}, pac_x, SX);
        check_eq({tag, "_y"}, pac_y, SY);
        check_eq({tag, "_dir"}, pac_dir, 2);
        check_eq({tag, "_moved"}, moved, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_qx"}, rom_if.query_x, 0);
        check_eq({tag, "_qy"}, rom_if.query_y, 0);
    endtask

    // One game tick: optional press 8 cycles ahead, then cycle-by-cycle comparison
    task automatic run_tick(input bit press, input int pd);
        int n, endc, tx, ty, tdir, ox, oy, od, qc, qx, qy, rx, ry;
        bit mv, qok, roob, post;
        n = next_tick;
        wait_cyc(n - 8);
        if (press) begin
            dir_valid = 1'b1;
            dir_req   = pd[1:0];
            step();
            dir_valid = 1'b0;
            m_pv = 1'b1;
            m_pd = pd;
        end
        ox = m_x; oy = m_y; od = m_dir;
        mv = 1'b0; tx = ox; ty = oy; tdir = od;
        if (m_pv) begin
            nbr(m_x, m_y, m_pd, rx, ry, roob);
            if (!roob && !maze[ry][rx]) begin
                mv = 1'b1; tx = rx; ty = ry; tdir = m_pd; endc = n + 4;
                qc = n + 1; qx = rx; qy = ry; qok = 1'b1;
                m_pv = 1'b0;
            end else begin
                nbr(m_x, m_y, m_dir, rx, ry, roob);
                qc = n + 3; qx = rx; qy = ry; qok = !roob;
                if (!roob && !maze[ry][rx]) begin
                    mv = 1'b1; tx = rx; ty = ry; endc = n + 6;
                end else begin
                    endc = n + 5;
                end
                if (!BUF) m_pv = 1'b0;
            end
        end else begin
            nbr(m_x, m_y, m_dir, rx, ry, roob);
            qc = n + 1; qx = rx; qy = ry; qok = !roob;
            if (!roob && !maze[ry][rx]) begin
                mv = 1'b1; tx = rx; ty = ry; endc = n + 4;
            end else begin
                endc = n + 3;
            end
        end
        for (int c = n; c <= n + 7; c++) begin
            wait_cyc(c);
            post = mv && (c >= endc);
            check_eq("busy", busy, (c > n) && (c < endc));
            check_eq("moved", moved, mv && (c == endc));
            check_eq("pac_x", pac_x, post ? tx : ox);
            check_eq("pac_y", pac_y, post ? ty : oy);
            check_eq("pac_dir", pac_dir, post ? tdir : od);
            if (c == qc && qok) begin
                check_eq("query_x", rom_if.query_x, qx);
                check_eq("query_y", rom_if.query_y, qy);
            end
        end
        if (mv) begin
            m_x = tx; m_y = ty; m_dir = tdir;
        end
        next_tick += TICK;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        errors = 0;
        checks = 0;
        cyc    = 0;
        fill_maze(0);

        do_reset();
        check_home("reset");

        // open maze, steady leftward motion
        for (int i = 0; i < 3; i++) run_tick(1'b0, 0);

        // reset in the MOVE cycle discards the pending update
        n = next_tick;
        wait_cyc(n + 1);
        check_eq("mid_busy", busy, 1);
        wait_cyc(n + 3);
        reset = 1'b1;
        step();
        check_home("mid_reset");
        reset = 1'b0;
        model_reset();

        // turn up into a clear tile
        run_tick(1'b1, 1);

        // up blocked: continue left, then buffered turn (or not) one tick later
        do_reset();
        maze[14][9] = 1'b1;
        run_tick(1'b1, 1);
        run_tick(1'b0, 0);
        maze[14][9] = 1'b0;

        // horizontal tunnel both ways
        do_reset();
        for (int i = 0; i < 10; i++) run_tick(1'b0, 0);
        run_tick(1'b1, 0);

        // top edge with the ROM returning clear everywhere
        do_reset();
        run_tick(1'b1, 1);
        for (int i = 0; i < 14; i++) run_tick(1'b0, 0);
        run_tick(1'b1, 1);
        run_tick(1'b0, 0);

        // gameover mid-evaluation, frozen counter, ignored press
        do_reset();
        n = next_tick;
        for (int c = n; c <= n + 7; c++) begin
            wait_cyc(c);
            if (c == n + 2) gameover = 1'b1;
            check_eq("go_busy", busy, (c == n + 1) || (c == n + 2));
            check_eq("go_moved", moved, 0);
            check_eq("go_x", pac_x, SX);
            check_eq("go_dir", pac_dir, 2);
        end
        wait_cyc(n + 10);
        dir_valid = 1'b1;
        dir_req   = 2'd1;
        step();
        dir_valid = 1'b0;
        wait_cyc(n + 17);
        check_eq("go_frozen_busy", busy, 0);
        check_eq("go_frozen_x", pac_x, SX);
        wait_cyc(n + 22);
        gameover  = 1'b0;
        next_tick = n + TICK + 20;
        run_tick(1'b0, 0);

        // randomised maze and presses
        do_reset();
        for (int i = 0; i < 48; i++) begin
            if (i % 6 == 0) fill_maze(25);
            run_tick($urandom_range(1) == 1, int'($urandom_range(3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
